// File: rtl/reg_access_ctrl_pkg.sv
// Shared configuration for the register-file access path: word/address
// widths, register count and the write-queue pop encoding.
package reg_access_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int NUM_REGS  = 16;
  localparam int WORD_SIZE = DATA_W;
  localparam int WQ_DEPTH  = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] regaddr_t;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

endpackage

// File: rtl/reg_access_ctrl_wq_fifo.sv
// In-order {addr,data} write queue with 1/2-entry pop and two address
// lookups that return the youngest matching entry's data.
module reg_access_ctrl_wq_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic [1:0]               pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [ADDR_W-1:0]        next_addr,
  output logic [DATA_W-1:0]        next_data,
  input  logic [ADDR_W-1:0]        lk_addr0,
  input  logic [ADDR_W-1:0]        lk_addr1,
  output logic [DEPTH-1:0]         match0,
  output logic [DEPTH-1:0]         match1,
  output logic [DATA_W-1:0]        sel_data0,
  output logic [DATA_W-1:0]        sel_data1
);
  import reg_access_ctrl_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     nxt_ptr;
  logic [CW-1:0]     pop_amt;
  logic [PW-1:0]     idx;

  always_comb begin
    case (pop)
      POP_ONE: pop_amt = CW'(1);
      POP_TWO: pop_amt = CW'(2);
      default: pop_amt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_amt);
      count  <= count + CW'(push) - pop_amt;
    end
  end

  // Storage is never reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign nxt_ptr   = rd_ptr + PW'(1);
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign next_addr = mem_addr[nxt_ptr];
  assign next_data = mem_data[nxt_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] age;
      logic          live;
      assign age        = PW'(gi) - rd_ptr;
      assign live       = {1'b0, age} < count;
      assign match0[gi] = live && (mem_addr[gi] == lk_addr0);
      assign match1[gi] = live && (mem_addr[gi] == lk_addr1);
    end
  endgenerate

  // Walk oldest to youngest so the last hit (youngest) wins.
  always_comb begin
    sel_data0 = '0;
    sel_data1 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (match0[idx]) sel_data0 = mem_data[idx];
      if (match1[idx]) sel_data1 = mem_data[idx];
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file initiator: operand reads take priority over queue drains;
// writebacks are queued and forwarded to reads until committed.
module reg_access_ctrl #(
  parameter int DATA_W   = reg_access_ctrl_pkg::DATA_W,
  parameter int ADDR_W   = reg_access_ctrl_pkg::ADDR_W,
  parameter int WQ_DEPTH = reg_access_ctrl_pkg::WQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [ADDR_W-1:0]          rd_addr0,
  input  logic [ADDR_W-1:0]          rd_addr1,
  output logic                       op_valid,
  output logic [DATA_W-1:0]          op_data0,
  output logic [DATA_W-1:0]          op_data1,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [ADDR_W-1:0]          rf_addr0,
  output logic [ADDR_W-1:0]          rf_addr1,
  output logic [DATA_W-1:0]          rf_din0,
  output logic [DATA_W-1:0]          rf_din1,
  output logic                       rf_we0,
  output logic                       rf_we1,
  input  logic [DATA_W-1:0]          rf_dout0,
  input  logic [DATA_W-1:0]          rf_dout1,
  output logic [$clog2(WQ_DEPTH):0]  wq_count,
  output logic                       idle
);
  import reg_access_ctrl_pkg::*;

  localparam int CW = $clog2(WQ_DEPTH) + 1;

  logic              wq_full;
  logic              rd_acc;
  logic              push;
  logic              drain;
  logic              pair_ok;
  pop_e              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] next_data;
  logic [WQ_DEPTH-1:0] match0;
  logic [WQ_DEPTH-1:0] match1;
  logic [DATA_W-1:0] sel_data0;
  logic [DATA_W-1:0] sel_data1;
  logic [ADDR_W-1:0] addr0_reg;
  logic [ADDR_W-1:0] addr1_reg;

  reg_access_ctrl_wq_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (pop),
    .count     (wq_count),
    .head_addr (head_addr),
    .head_data (head_data),
    .next_addr (next_addr),
    .next_data (next_data),
    .lk_addr0  (rd_addr0),
    .lk_addr1  (rd_addr1),
    .match0    (match0),
    .match1    (match1),
    .sel_data0 (sel_data0),
    .sel_data1 (sel_data1)
  );

  assign wq_full  = (wq_count == CW'(WQ_DEPTH));
  assign rd_ready = !wq_full;
  assign wb_ready = !wq_full;

  // Gating with rst makes the write enables collapse the moment reset rises.
  assign rd_acc  = rd_valid && !wq_full && !rst;
  assign push    = wb_valid && !wq_full && !rst;
  assign drain   = !rd_acc && (wq_count != '0) && !rst;
  // Same-address pair would race on the two ports, so only the head goes.
  assign pair_ok = (wq_count >= CW'(2)) && (next_addr != head_addr);
  assign pop     = !drain ? POP_NONE : (pair_ok ? POP_TWO : POP_ONE);

  assign rf_we0   = drain;
  assign rf_we1   = drain && pair_ok;
  assign rf_addr0 = rd_acc ? rd_addr0 : (rf_we0 ? head_addr : addr0_reg);
  assign rf_addr1 = rd_acc ? rd_addr1 : (rf_we1 ? next_addr : addr1_reg);
  assign rf_din0  = rf_we0 ? head_data : '0;
  assign rf_din1  = rf_we1 ? next_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr0_reg <= '0;
      addr1_reg <= '0;
      op_valid  <= 1'b0;
      op_data0  <= '0;
      op_data1  <= '0;
    end else begin
      addr0_reg <= rf_addr0;
      addr1_reg <= rf_addr1;
      op_valid  <= rd_acc;
      if (rd_acc) begin
        op_data0 <= (|match0) ? sel_data0 : rf_dout0;
        op_data1 <= (|match1) ? sel_data1 : rf_dout1;
      end
    end
  end

  assign idle = (wq_count == '0) && !op_valid;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: behavioural register file on the rf_* ports and
// an architectural model (newest value per register plus a pending-write list).
module tb_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  rd_addr0;
  logic [3:0]  rd_addr1;
  logic        op_valid;
  logic [31:0] op_data0;
  logic [31:0] op_data1;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  rf_addr0;
  logic [3:0]  rf_addr1;
  logic [31:0] rf_din0;
  logic [31:0] rf_din1;
  logic        rf_we0;
  logic        rf_we1;
  logic [31:0] rf_dout0;
  logic [31:0] rf_dout1;
  logic [2:0]  wq_count;
  logic        idle;

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .op_valid (op_valid),
    .op_data0 (op_data0),
    .op_data1 (op_data1),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rf_addr0 (rf_addr0),
    .rf_addr1 (rf_addr1),
    .rf_din0  (rf_din0),
    .rf_din1  (rf_din1),
    .rf_we0   (rf_we0),
    .rf_we1   (rf_we1),
    .rf_dout0 (rf_dout0),
    .rf_dout1 (rf_dout1),
    .wq_count (wq_count),
    .idle     (idle)
  );

  // Register file attached to the DUT
  logic        load;
  logic [31:0] rf_init [16];
  logic [31:0] rf_mem  [16];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init[i];
    end else begin
      if (rf_we0) rf_mem[rf_addr0] <= rf_din0;
      if (rf_we1) rf_mem[rf_addr1] <= rf_din1;
    end
  end
  assign rf_dout0 = rf_mem[rf_addr0];
  assign rf_dout1 = rf_mem[rf_addr1];

  // Reference model
  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        q [$];
  logic [31:0] arch [16];
  logic [31:0] cm   [16];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [3:0] a0, input logic [3:0] a1,
                      input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                      input bit do_rst);
    bit          full, acc, psh, drn, we1e;
    logic [31:0] e0, e1;
    @(negedge clk);
    rst = 1'b0;
    rd_valid = rv; rd_addr0 = a0; rd_addr1 = a1;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    #1;
    full = (q.size() == 4);
    acc  = rv && !full;
    psh  = wv && !full;
    drn  = !acc && (q.size() > 0);
    we1e = drn && (q.size() >= 2) && (q[1].a != q[0].a);
    check("rd_ready", 32'(rd_ready), 32'(!full));
    check("wb_ready", 32'(wb_ready), 32'(!full));
    check("rf_we0", 32'(rf_we0), 32'(drn));
    check("rf_we1", 32'(rf_we1), 32'(we1e));
    if (drn) begin
      check("drain_addr0", 32'(rf_addr0), 32'(q[0].a));
      check("drain_din0", rf_din0, q[0].d);
    end
    if (we1e) begin
      check("drain_addr1", 32'(rf_addr1), 32'(q[1].a));
      check("drain_din1", rf_din1, q[1].d);
    end
    e0 = arch[a0];
    e1 = arch[a1];
    if (acc) begin
      check("read_addr0", 32'(rf_addr0), 32'(a0));
      check("read_addr1", 32'(rf_addr1), 32'(a1));
    end
    $display("step rv=%0b a=(%0d,%0d) wv=%0b wb=r%0d<-%0h acc=%0b push=%0b drain=%0b pair=%0b rst=%0b",
             rv, a0, a1, wv, wa, wd, acc, psh, drn, we1e, do_rst);
    if (do_rst) begin
      #1 rst = 1'b1;
      #1;
      check("rst_we0", 32'(rf_we0), 32'd0);
      check("rst_we1", 32'(rf_we1), 32'd0);
      check("rst_count", 32'(wq_count), 32'd0);
      check("rst_op_valid", 32'(op_valid), 32'd0);
      q.delete();
      for (int i = 0; i < 16; i++) arch[i] = cm[i];
      @(posedge clk); #1;
      check("rst_count_hold", 32'(wq_count), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
    end else begin
      if (drn) begin
        cm[q[0].a] = q[0].d;
        void'(q.pop_front());
        if (we1e) begin
          cm[q[0].a] = q[0].d;
          void'(q.pop_front());
        end
      end
      if (psh) begin
        q.push_back('{a: wa, d: wd});
        arch[wa] = wd;
      end
      @(posedge clk); #1;
      check("op_valid", 32'(op_valid), 32'(acc));
      if (acc) begin
        check("op_data0", op_data0, e0);
        check("op_data1", op_data1, e1);
      end
      check("wq_count", 32'(wq_count), 32'(q.size()));
      check("idle", 32'(idle), 32'(q.size() == 0 && !acc));
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 16; i++) check($sformatf("rf[%0d]", i), rf_mem[i], cm[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b1;
    rd_valid = 1'b0; rd_addr0 = '0; rd_addr1 = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 16; i++) rf_init[i] = $urandom;
    rf_init[3] = 32'h11;
    rf_init[5] = 32'h22;
    rf_init[9] = 32'hAA;
    for (int i = 0; i < 16; i++) begin
      arch[i] = rf_init[i];
      cm[i]   = rf_init[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    #1;
    check("reset_count", 32'(wq_count), 32'd0);
    check("reset_op_valid", 32'(op_valid), 32'd0);
    check("reset_op_data0", op_data0, 32'd0);
    check("reset_op_data1", op_data1, 32'd0);
    check("reset_we", 32'({rf_we0, rf_we1}), 32'd0);
    check("reset_addr", 32'({rf_addr0, rf_addr1}), 32'd0);
    check("reset_din0", rf_din0, 32'd0);
    check("reset_din1", rf_din1, 32'd0);
    check("reset_ready", 32'({rd_ready, wb_ready}), 32'd3);
    check("reset_idle", 32'(idle), 32'd1);
    rst = 1'b0;

    // Plain read from the register file
    step(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 32'd0, 1'b0);
    check("plan_r3", op_data0, 32'h11);
    check("plan_r5", op_data1, 32'h22);

    // Forwarding from a queued write, then the drain
    step(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    step(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    check("plan_fwd", op_data1, 32'hDEADBEEF);
    idle_steps(1);

    // Back-to-back writes to one register; youngest value wins
    step(1'b1, 4'd1, 4'd1, 1'b1, 4'd7, 32'h1, 1'b0);
    step(1'b1, 4'd2, 4'd2, 1'b1, 4'd7, 32'h2, 1'b0);
    step(1'b1, 4'd7, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    check("plan_r7_fwd", op_data0, 32'h2);
    idle_steps(3);
    check("plan_r7_rf", rf_mem[7], 32'h2);

    // Fill the queue with reads held high; full blocks the read for one drain
    for (int i = 1; i <= 4; i++)
      step(1'b1, 4'd0, 4'd0, 1'b1, 4'(i), 32'h100 + 32'(i), 1'b0);
    step(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0);
    step(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0);
    idle_steps(2);

    // Read and write of the same register in one cycle
    step(1'b1, 4'd9, 4'd9, 1'b1, 4'd9, 32'h55, 1'b0);
    check("plan_r9_old", op_data0, 32'hAA);
    idle_steps(1);
    check("plan_r9_rf", rf_mem[9], 32'h55);
    check_rf();

    // Reset in the middle of a drain
    step(1'b1, 4'd0, 4'd1, 1'b1, 4'd10, 32'hA0A0, 1'b0);
    step(1'b1, 4'd2, 4'd3, 1'b1, 4'd11, 32'hB1B1, 1'b0);
    step(1'b1, 4'd4, 4'd5, 1'b1, 4'd12, 32'hC2C2, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    idle_steps(1);
    check_rf();

    // Randomized traffic
    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 9) < 5), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), $urandom, 1'b0);
    idle_steps(4);
    check_rf();
    for (int i = 0; i < 16; i++) check($sformatf("arch[%0d]", i), rf_mem[i], arch[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
